// File: rtl/square_wave_period_meter.sv
// Square-wave period/high-time meter with loss-of-signal timeout.
// Optional glitch rejection stage: define SQW_METER_GLITCH_FILTER_EN.
module square_wave_period_meter #(
    parameter int unsigned CLK_FREQ       = 1_000_000,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sq_in,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 period_valid,
    output logic                 no_signal
);

    localparam int unsigned TO_LAST = TIMEOUT_CYCLES - 1;

    // Reject configurations where cnt+1 could wrap or the timeout is too short
    if (TIMEOUT_CYCLES < 4 || 64'(TIMEOUT_CYCLES) > ((64'(1) << CNT_WIDTH) - 64'(1))
        || CLK_FREQ == 0) begin : g_bad_cfg
        $error("square_wave_period_meter: illegal TIMEOUT_CYCLES/CNT_WIDTH/CLK_FREQ");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 lvl_q, lvl_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 nosig_q, nosig_d;
    logic                 det_c;
    logic                 rise_c;
    logic                 fall_c;
    logic                 timeout_c;
    logic [CNT_WIDTH-1:0] cnt_inc_c;

`ifdef SQW_METER_GLITCH_FILTER_EN
    logic filt_q, filt_d;

    // Filtered level follows sync2 only once the value is about to be held twice
    always_comb begin
        filt_d = filt_q;
        if (sync1_q == sync2_q) begin
            filt_d = sync2_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign det_c = filt_q;
`else
    assign det_c = sync2_q;
`endif

    // Synchronizer and edge detection
    always_comb begin
        sync1_d = sq_in;
        sync2_d = sync1_q;
        lvl_d   = det_c;
        rise_c  = det_c & ~lvl_q;
        fall_c  = ~det_c & lvl_q;
    end

    assign cnt_inc_c = cnt_q + CNT_WIDTH'(1);
    assign timeout_c = (cnt_q == CNT_WIDTH'(TO_LAST));

    // Measurement FSM; enable low overrides any edge or timeout
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_lat_d = hi_lat_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        nosig_d  = nosig_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_FIRST;
                    cnt_d   = '0;
                end
                WAIT_FIRST: begin
                    cnt_d = cnt_inc_c;
                    if (rise_c) begin
                        cnt_d   = '0;
                        state_d = MEASURE;
                    end else if (timeout_c) begin
                        nosig_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
                MEASURE: begin
                    cnt_d = cnt_inc_c;
                    if (fall_c) begin
                        hi_lat_d = cnt_inc_c;
                    end
                    if (rise_c) begin
                        period_d = cnt_inc_c;
                        high_d   = hi_lat_q;
                        valid_d  = 1'b1;
                        nosig_d  = 1'b0;
                        cnt_d    = '0;
                    end else if (timeout_c) begin
                        nosig_d = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_FIRST;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            lvl_q    <= 1'b0;
            cnt_q    <= '0;
            hi_lat_q <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            nosig_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            lvl_q    <= lvl_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            nosig_q  <= nosig_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = valid_q;
    assign no_signal    = nosig_q;

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Directed bench for square_wave_period_meter: a default-size instance and a
// 4-bit / timeout-15 instance for the counter boundary.
module tb_square_wave_period_meter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sq_a, en_a, sq_b, en_b;
    logic [15:0] per_a, hi_a;
    logic        pv_a, ns_a;
    logic [3:0]  per_b, hi_b;
    logic        pv_b, ns_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stb_a = 0;
    int stb_b = 0;
    int last_stb = 0;
    int prev_stb = 0;
    int per_hist [0:511];

    always #5 clk = ~clk;

    square_wave_period_meter #(
        .CLK_FREQ(1_000_000), .CNT_WIDTH(16), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sq_in(sq_a), .enable(en_a),
        .period(per_a), .high_time(hi_a), .period_valid(pv_a), .no_signal(ns_a)
    );

    square_wave_period_meter #(
        .CLK_FREQ(1_000_000), .CNT_WIDTH(4), .TIMEOUT_CYCLES(15)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .sq_in(sq_b), .enable(en_b),
        .period(per_b), .high_time(hi_b), .period_valid(pv_b), .no_signal(ns_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log, sampled on the falling edge
    always @(negedge clk) begin
        if (pv_a === 1'b1) begin
            if (stb_a < 512) per_hist[stb_a] <= int'(per_a);
            prev_stb <= last_stb;
            last_stb <= cyc;
            stb_a    <= stb_a + 1;
        end
        if (pv_b === 1'b1) stb_b <= stb_b + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic wave_a(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sq_a = 1'b1; repeat (hi) @(negedge clk);
            sq_a = 1'b0; repeat (lo) @(negedge clk);
        end
    endtask

    task automatic wave_b(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sq_b = 1'b1; repeat (hi) @(negedge clk);
            sq_b = 1'b0; repeat (lo) @(negedge clk);
        end
    endtask

    initial begin
        int s0, s1, n, mn;
        reset_n = 1'b0; sq_a = 1'b0; en_a = 1'b0; sq_b = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_period", int'(per_a), 0);
        chk("rst_high", int'(hi_a), 0);
        chk("rst_valid", int'(pv_a), 0);
        chk("rst_nosig", int'(ns_a), 0);

        // 10/10 wave: first rise only arms
        reset_n = 1'b1;
        @(negedge clk);
        en_a = 1'b1;
        s0 = stb_a;
        wave_a(10, 10, 4);
        #1;
        chk("basic_strobes", stb_a - s0, 3);
        chk("basic_period", int'(per_a), 20);
        chk("basic_high", int'(hi_a), 10);
        chk("basic_nosig", int'(ns_a), 0);
        chk("basic_spacing", last_stb - prev_stb, 20);

        // 7/13 duty
        s0 = stb_a;
        wave_a(7, 13, 4);
        #1;
        chk("duty_strobes", stb_a - s0, 4);
        chk("duty_period", int'(per_a), 20);
        chk("duty_high", int'(hi_a), 7);

        // Input stops low
        n = 0;
        while (ns_a !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("timeout_delay", cyc - last_stb, 1024);
        chk("timeout_period_hold", int'(per_a), 20);
        chk("timeout_high_hold", int'(hi_a), 7);

        // Restart: strobe only on the second rise
        s0 = stb_a;
        wave_a(10, 10, 2);
        #1;
        chk("restart_strobes", stb_a - s0, 1);
        chk("restart_nosig", int'(ns_a), 0);
        chk("restart_period", int'(per_a), 20);
        chk("restart_high", int'(hi_a), 10);

        // Drop enable 5 clocks into a period
        s0 = stb_a;
        sq_a = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("en_pre_strobe", stb_a - s0, 1);
        s1 = stb_a;
        en_a = 1'b0;
        repeat (5) @(negedge clk);
        sq_a = 1'b0;
        repeat (10) @(negedge clk);
        wave_a(10, 10, 1);
        #1;
        chk("en_off_strobes", stb_a - s1, 0);
        chk("en_off_period", int'(per_a), 20);
        chk("en_off_nosig", int'(ns_a), 0);
        s0 = stb_a;
        en_a = 1'b1;
        wave_a(10, 10, 3);
        #1;
        chk("reen_strobes", stb_a - s0, 2);

        // One-clock glitch inside a low phase
        s0 = stb_a;
        sq_a = 1'b1; repeat (10) @(negedge clk);
        sq_a = 1'b0; repeat (4) @(negedge clk);
        sq_a = 1'b1; repeat (1) @(negedge clk);
        sq_a = 1'b0; repeat (5) @(negedge clk);
        wave_a(10, 10, 2);
        #1;
        mn = 99999;
        for (int i = s0; i < stb_a && i < 512; i++) begin
            if (per_hist[i] < mn) mn = per_hist[i];
        end
`ifdef SQW_METER_GLITCH_FILTER_EN
        chk("glitch_strobes", stb_a - s0, 3);
        chk("glitch_min_period", mn, 20);
`else
        chk("glitch_strobes", stb_a - s0, 4);
        chk("glitch_min_period", mn, 6);
`endif
        chk("glitch_period", int'(per_a), 20);
        chk("glitch_high", int'(hi_a), 10);

        // Asynchronous reset mid-period
        sq_a = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_period", int'(per_a), 0);
        chk("arst_high", int'(hi_a), 0);
        chk("arst_valid", int'(pv_a), 0);
        chk("arst_nosig", int'(ns_a), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sq_a = 1'b0;
        en_a = 1'b0;

        // 4-bit counter, timeout 15: period 14 fits, 16 times out
        @(negedge clk);
        en_b = 1'b1;
        s0 = stb_b;
        wave_b(7, 7, 4);
        #1;
        chk("bnd14_strobes", stb_b - s0, 3);
        chk("bnd14_period", int'(per_b), 14);
        chk("bnd14_high", int'(hi_b), 7);
        chk("bnd14_nosig", int'(ns_b), 0);
        s0 = stb_b;
        wave_b(8, 8, 4);
        #1;
        chk("bnd16_strobes", stb_b - s0, 1);
        chk("bnd16_nosig", int'(ns_b), 1);
        chk("bnd16_period_hold", int'(per_b), 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_wave_period_meter.md
# square_wave_period_meter

Measures an incoming square wave (e.g. a generated bit clock or tone looped back on the i2s path) in units of the system clock. It synchronizes the asynchronous input, detects edges, and reports period and high time once per input cycle with a one-cycle valid strobe. It flags loss of signal after a programmable timeout. It sits on the receive side of the generator chain and is used for self-check and frequency calibration.

## Interface
- CLK_FREQ, 1_000_000: system clock frequency in Hz. Documentation only; no logic depends on it.
- CNT_WIDTH, 16: width of the period and high-time results.
- TIMEOUT_CYCLES, 1024: number of clocks without a rising edge before `no_signal` asserts. Legal range is 4 to 2^CNT_WIDTH−1.
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- sq_in  input  1  square wave under measurement; asynchronous to `clk`.
- enable  input  1  measurement enable; level-sensitive.
- period  output  CNT_WIDTH  last measured rising-to-rising interval, in clocks.
- high_time  output  CNT_WIDTH  last measured rising-to-falling interval, in clocks.
- period_valid  output  1  one-cycle strobe: `period` and `high_time` were just updated.
- no_signal  output  1  sticky level: timeout expired since the last valid measurement.

## Operation
- **Input conditioning:** `sq_in` passes through a 2-FF synchronizer (sync1, sync2) into a level register `lvl_d`.
  - rise = sync2 & ~lvl_d.
  - fall = ~sync2 & lvl_d.
  - rise and fall are mutually exclusive by construction.
- **Free-running counter:** `cnt` (CNT_WIDTH bits) increments every clock in WAIT_FIRST and MEASURE and is cleared on entry to either state.
- **States:**
  - IDLE: entered on reset or when `enable`=0. `cnt`=0; outputs hold their values. Moves to WAIT_FIRST when `enable`=1.
  - WAIT_FIRST: on rise, `cnt`←0 and move to MEASURE with no strobe; the first edge only arms the measurement.
  - MEASURE:
    - On fall, `hi_lat`←`cnt`+1.
    - On rise, `period`←`cnt`+1, `high_time`←`hi_lat`, `period_valid`←1, `no_signal`←0, `cnt`←0, and stay in MEASURE.
  - **Timeout:** in WAIT_FIRST or MEASURE, when `cnt`==TIMEOUT_CYCLES−1 and there is no rise that cycle: `no_signal`←1, `cnt`←0, move to WAIT_FIRST. `period` and `high_time` hold.
- **Rise and timeout in the same cycle:** rise wins, and the measurement is reported normally.
- **`enable` falling mid-measurement:** next state is IDLE, the partial measurement is discarded, and no strobe is issued. `no_signal` holds.
- **Reset assertion (any time):** immediate return to IDLE. `period`=0, `high_time`=0, `hi_lat`=0, `period_valid`=0, `no_signal`=0, synchronizer flops=0.
- **Arithmetic:** `cnt`+1 never wraps, because TIMEOUT_CYCLES ≤ 2^CNT_WIDTH−1 bounds `cnt`.

## Timing
- **Latency:** an `sq_in` rising edge sampled at clk edge k gives sync2=1 after edge k+1. `period_valid` is high in the cycle after edge k+2 (3 edges, filter off).
- **Strobe width:** `period_valid` is exactly 1 cycle. Its minimum spacing equals the measured period.
- **Measurement accuracy:** ±1 clock per edge due to synchronizer sampling. For a clean, synchronous-rate input of period P clocks, `period`=P exactly.
- **Minimum input half-period:** 2 clocks. Shorter pulses may be missed.

## Configuration
- **`SQW_METER_GLITCH_FILTER_EN` defined:**
  - adds a stage between sync2 and edge detection;
  - filtered level updates only when sync2 has held the same value for 2 consecutive clocks;
  - single-clock glitches on `sq_in` are rejected;
  - latency grows by 1 clock (4 edges);
  - minimum half-period becomes 3 clocks.
- **Not defined:** edge detection uses sync2 directly, as in Timing.

## Test plan
- **Basic measurement:** reset, `enable`=1, `sq_in` = 50 kHz square wave with 1 MHz `clk` (toggle every 10 clocks) → first strobe after the second rising edge, `period`=20, `high_time`=10, `no_signal`=0; strobes repeat every 20 clocks.
- **Duty cycle:** high 7 / low 13 clocks → `period`=20, `high_time`=7.
- **Timeout:** TIMEOUT_CYCLES=1024; stop `sq_in` low after a valid measurement → `no_signal`=1 exactly 1024 clocks after the last counted rise; `period` holds 20. Restart the input → no strobe on the first rise; strobe with `no_signal`=0 on the second.
- **Enable and reset mid-measurement:** drop `enable` 5 clocks into a period → no strobe, outputs hold. Re-enable → first strobe only after two rises. Pulse `reset_n` low mid-period → all outputs 0 immediately, asynchronously.
- **Glitch filter:** insert a 1-clock high glitch into a low phase. With `SQW_METER_GLITCH_FILTER_EN` defined → no extra strobe, `period`=20. Without it → a spurious strobe with `period`<20.
- **Boundary:** CNT_WIDTH=4, TIMEOUT_CYCLES=15, input period 14 → `period`=14, no timeout. Input period 16 → `no_signal`=1 and no strobe.
